register_operand_fetch: RTL and testbench

Operand-fetch stage with the architectural register file. It sits between decode and execute, and it is the consumer of the writeback stage's register-file write port (`write_index_rf`, `write_data_rf`, `write_en_rf`). It holds 32 × 16-bit registers and reads two source operands per instruction. A per-register pending scoreboard stalls decode until in-flight writes retire, and same-cycle writebacks are bypassed. The issued operands are registered into a valid/stall pipeline register that feeds execute.

---
 rtl/core_pkg.sv | 13 +
 rtl/register_operand_fetch_if.sv | 48 ++++
 rtl/register_file_2r1w.sv | 45 ++++
 rtl/register_operand_fetch.sv | 100 ++++++++++
 tb/tb_register_operand_fetch.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// core_pkg: constants shared by the operand-fetch and writeback stages.
//   DATA_W   register / operand width
//   INDEX_W  register index width (2**INDEX_W registers)
//   CTRL_W   opcode width
//   LOAD, STORE  opcodes that travel through operand fetch untouched
package core_pkg;
    localparam int DATA_W  = 16;
    localparam int INDEX_W = 5;
    localparam int CTRL_W  = 4;

    localparam logic [CTRL_W-1:0] LOAD  = 4'b1100;
    localparam logic [CTRL_W-1:0] STORE = 4'b1110;
endpackage

// File: rtl/register_operand_fetch_if.sv
// register_operand_fetch_if: bundle of the writeback write port, the decode
// issue handshake and the execute pipeline-register outputs.
//   slave  : view of the operand-fetch stage itself
//   master : view of the surrounding pipeline (decode / writeback / execute)
interface register_operand_fetch_if;
    import core_pkg::*;

    // writeback -> register file
    logic [INDEX_W-1:0] write_index_rf;
    logic [DATA_W-1:0]  write_data_rf;
    logic               write_en_rf;
    // decode -> operand fetch
    logic               valid_id;
    logic [INDEX_W-1:0] src_a_index_id;
    logic [INDEX_W-1:0] src_b_index_id;
    logic [INDEX_W-1:0] dest_reg_index_id;
    logic               dest_reg_write_en_id;
    logic [CTRL_W-1:0]  control_id;
    logic               ready_id;
    // operand fetch -> execute
    logic               stall_ex;
    logic               valid_ex;
    logic [DATA_W-1:0]  operand_a_ex;
    logic [DATA_W-1:0]  operand_b_ex;
    logic [INDEX_W-1:0] dest_reg_index_ex;
    logic               dest_reg_write_en_ex;
    logic [CTRL_W-1:0]  control_ex;

    modport slave (
        input  write_index_rf, write_data_rf, write_en_rf,
        input  valid_id, src_a_index_id, src_b_index_id,
        input  dest_reg_index_id, dest_reg_write_en_id, control_id,
        output ready_id,
        input  stall_ex,
        output valid_ex, operand_a_ex, operand_b_ex,
        output dest_reg_index_ex, dest_reg_write_en_ex, control_ex
    );

    modport master (
        output write_index_rf, write_data_rf, write_en_rf,
        output valid_id, src_a_index_id, src_b_index_id,
        output dest_reg_index_id, dest_reg_write_en_id, control_id,
        input  ready_id,
        output stall_ex,
        input  valid_ex, operand_a_ex, operand_b_ex,
        input  dest_reg_index_ex, dest_reg_write_en_ex, control_ex
    );
endinterface

// File: rtl/register_file_2r1w.sv
// register_file_2r1w: 2**INDEX_W x DATA_W register file, one synchronous
// write port, two combinational read ports.
//   clk, reset          clock, synchronous active-high reset (clears all)
//   i_we/i_waddr/i_wdata write port; writes to index 0 are dropped
//   i_raddr_a/b          read indices
//   o_rdata_a/b          read data: r0 reads 0, a same-cycle write is bypassed
module register_file_2r1w #(
    parameter int DATA_W  = core_pkg::DATA_W,
    parameter int INDEX_W = core_pkg::INDEX_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_we,
    input  logic [INDEX_W-1:0] i_waddr,
    input  logic [DATA_W-1:0]  i_wdata,
    input  logic [INDEX_W-1:0] i_raddr_a,
    input  logic [INDEX_W-1:0] i_raddr_b,
    output logic [DATA_W-1:0]  o_rdata_a,
    output logic [DATA_W-1:0]  o_rdata_b
);
    localparam int NUM_REGS = 1 << INDEX_W;

    logic [DATA_W-1:0] r_regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (i_we && i_waddr != '0) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // r0 check first so a writeback aimed at r0 can never leak through the bypass
    always_comb begin
        o_rdata_a = r_regs[i_raddr_a];
        if (i_raddr_a == '0)                   o_rdata_a = '0;
        else if (i_we && i_waddr == i_raddr_a) o_rdata_a = i_wdata;
    end

    always_comb begin
        o_rdata_b = r_regs[i_raddr_b];
        if (i_raddr_b == '0)                   o_rdata_b = '0;
        else if (i_we && i_waddr == i_raddr_b) o_rdata_b = i_wdata;
    end
endmodule

// File: rtl/register_operand_fetch.sv
// register_operand_fetch: operand-fetch stage. Reads two sources from the
// architectural register file (with writeback bypass), tracks in-flight
// destination writes in a pending scoreboard to block RAW/WAW hazards, and
// registers the issued instruction into a valid/stall pipeline register.
//   clk, reset  clock, synchronous active-high reset
//   bus         slave side of register_operand_fetch_if:
//               writeback port (_rf), decode handshake (_id, ready_id out),
//               execute pipeline register (_ex out, stall_ex in)
module register_operand_fetch #(
    parameter int DATA_W  = core_pkg::DATA_W,
    parameter int INDEX_W = core_pkg::INDEX_W,
    parameter int CTRL_W  = core_pkg::CTRL_W
) (
    input  logic                      clk,
    input  logic                      reset,
    register_operand_fetch_if.slave   bus
);
    localparam int NUM_REGS = 1 << INDEX_W;

    logic [DATA_W-1:0]   w_rd_a, w_rd_b;
    logic [NUM_REGS-1:0] r_pend, w_wb_clr, w_iss_set, w_pend_eff;
    logic                w_hazard, w_space, w_accept;

    logic                r_valid;
    logic [DATA_W-1:0]   r_op_a, r_op_b;
    logic [INDEX_W-1:0]  r_dest;
    logic                r_dest_we;
    logic [CTRL_W-1:0]   r_control;

    register_file_2r1w #(
        .DATA_W  (DATA_W),
        .INDEX_W (INDEX_W)
    ) u_rf (
        .clk       (clk),
        .reset     (reset),
        .i_we      (bus.write_en_rf),
        .i_waddr   (bus.write_index_rf),
        .i_wdata   (bus.write_data_rf),
        .i_raddr_a (bus.src_a_index_id),
        .i_raddr_b (bus.src_b_index_id),
        .o_rdata_a (w_rd_a),
        .o_rdata_b (w_rd_b)
    );

    // A writeback retiring this cycle already satisfies its waiters: mask it
    // out of the scoreboard so the blocked instruction issues on the bypass.
    always_comb begin
        w_wb_clr = '0;
        if (bus.write_en_rf) w_wb_clr[bus.write_index_rf] = 1'b1;
        w_pend_eff    = r_pend & ~w_wb_clr;
        w_pend_eff[0] = 1'b0;
    end

    assign w_hazard = w_pend_eff[bus.src_a_index_id]
                    | w_pend_eff[bus.src_b_index_id]
                    | (bus.dest_reg_write_en_id & w_pend_eff[bus.dest_reg_index_id]);
    assign w_space  = ~r_valid | ~bus.stall_ex;
    assign w_accept = ~reset & bus.valid_id & ~w_hazard & w_space;

    always_comb begin
        w_iss_set = '0;
        if (w_accept && bus.dest_reg_write_en_id && bus.dest_reg_index_id != '0)
            w_iss_set[bus.dest_reg_index_id] = 1'b1;
    end

    // Set is OR-ed after the clear so a new issue to rX outranks rX retiring.
    always_ff @(posedge clk) begin
        if (reset) r_pend <= '0;
        else       r_pend <= (r_pend & ~w_wb_clr) | w_iss_set;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_dest    <= '0;
            r_dest_we <= 1'b0;
            r_control <= '0;
        end else if (w_accept) begin
            r_valid   <= 1'b1;
            r_op_a    <= w_rd_a;
            r_op_b    <= w_rd_b;
            r_dest    <= bus.dest_reg_index_id;
            r_dest_we <= bus.dest_reg_write_en_id;
            r_control <= bus.control_id;
        end else if (w_space) begin
            // bubble: only the valid bit drops, data fields keep their value
            r_valid   <= 1'b0;
        end
    end

    assign bus.ready_id             = w_accept;
    assign bus.valid_ex             = r_valid;
    assign bus.operand_a_ex         = r_op_a;
    assign bus.operand_b_ex         = r_op_b;
    assign bus.dest_reg_index_ex    = r_dest;
    assign bus.dest_reg_write_en_ex = r_dest_we;
    assign bus.control_ex           = r_control;
endmodule

// File: tb/tb_register_operand_fetch.sv
// Bench for register_operand_fetch: a directed per-cycle table covering the
// reset, bypass, RAW, backpressure, WAW and r0 scenarios, followed by a
// randomized run checked against an array-based model of the stage.
module tb_register_operand_fetch;
    import core_pkg::*;

    typedef struct {
        logic        rst, wen;
        logic [4:0]  widx;
        logic [15:0] wdata;
        logic        vld;
        logic [4:0]  sa, sb, dst;
        logic        dwe;
        logic [3:0]  ctrl;
        logic        stall;
        // expected: ready before the edge, _ex outputs after it
        logic        e_rdy, e_v;
        logic [15:0] e_a, e_b;
        logic [4:0]  e_dst;
        logic        e_dwe;
        logic [3:0]  e_ctrl;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    register_operand_fetch_if bus();

    register_operand_fetch dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset                    = v.rst;
        bus.write_en_rf          = v.wen;
        bus.write_index_rf       = v.widx;
        bus.write_data_rf        = v.wdata;
        bus.valid_id             = v.vld;
        bus.src_a_index_id       = v.sa;
        bus.src_b_index_id       = v.sb;
        bus.dest_reg_index_id    = v.dst;
        bus.dest_reg_write_en_id = v.dwe;
        bus.control_id           = v.ctrl;
        bus.stall_ex             = v.stall;
    endtask

    task automatic chk_ex(input int cyc, input vec_t v);
        chk("valid_ex",  cyc, 32'(bus.valid_ex),             32'(v.e_v));
        chk("operand_a", cyc, 32'(bus.operand_a_ex),         32'(v.e_a));
        chk("operand_b", cyc, 32'(bus.operand_b_ex),         32'(v.e_b));
        chk("dest_ex",   cyc, 32'(bus.dest_reg_index_ex),    32'(v.e_dst));
        chk("dest_we",   cyc, 32'(bus.dest_reg_write_en_ex), 32'(v.e_dwe));
        chk("control",   cyc, 32'(bus.control_ex),           32'(v.e_ctrl));
    endtask

    function automatic vec_t mk(
        input logic rst, wen, input logic [4:0] widx, input logic [15:0] wdata,
        input logic vld, input logic [4:0] sa, sb, dst, input logic dwe,
        input logic [3:0] ctrl, input logic stall,
        input logic e_rdy, e_v, input logic [15:0] e_a, e_b,
        input logic [4:0] e_dst, input logic e_dwe, input logic [3:0] e_ctrl);
        vec_t v;
        v.rst = rst; v.wen = wen; v.widx = widx; v.wdata = wdata; v.vld = vld;
        v.sa = sa; v.sb = sb; v.dst = dst; v.dwe = dwe; v.ctrl = ctrl; v.stall = stall;
        v.e_rdy = e_rdy; v.e_v = e_v; v.e_a = e_a; v.e_b = e_b;
        v.e_dst = e_dst; v.e_dwe = e_dwe; v.e_ctrl = e_ctrl;
        return v;
    endfunction

    // ---- reference model: plain arrays following the stage's rules ----
    logic [15:0] m_regs [32];
    bit          m_pend [32];
    logic        m_v, m_dwe;
    logic [15:0] m_a, m_b;
    logic [4:0]  m_dst;
    logic [3:0]  m_ctrl;

    function automatic logic [15:0] m_read(input vec_t s, input logic [4:0] i);
        if (i == 0) return 16'd0;
        if (s.wen && s.widx == i) return s.wdata;
        return m_regs[i];
    endfunction

    function automatic bit m_busy(input vec_t s, input logic [4:0] i);
        return (i != 0) && m_pend[i] && !(s.wen && s.widx == i);
    endfunction

    function automatic bit m_ready(input vec_t s);
        bit haz, space;
        haz   = m_busy(s, s.sa) || m_busy(s, s.sb) || (s.dwe && m_busy(s, s.dst));
        space = !m_v || !s.stall;
        return !s.rst && s.vld && !haz && space;
    endfunction

    task automatic m_step(input vec_t s);
        bit acc, space;
        logic [15:0] a, b;
        acc   = m_ready(s);
        space = !m_v || !s.stall;
        a     = m_read(s, s.sa);
        b     = m_read(s, s.sb);
        if (s.rst) begin
            for (int i = 0; i < 32; i++) begin m_regs[i] = 0; m_pend[i] = 0; end
            m_v = 0; m_a = 0; m_b = 0; m_dst = 0; m_dwe = 0; m_ctrl = 0;
        end else begin
            if (s.wen && s.widx != 0) m_regs[s.widx] = s.wdata;
            if (s.wen) m_pend[s.widx] = 0;
            if (acc) begin
                m_v = 1; m_a = a; m_b = b; m_dst = s.dst; m_dwe = s.dwe; m_ctrl = s.ctrl;
                if (s.dwe && s.dst != 0) m_pend[s.dst] = 1;
            end else if (space) begin
                m_v = 0;
            end
        end
    endtask

    vec_t tbl [$];

    initial begin
        vec_t s;
        //        rst wen widx wdata vld sa sb dst dwe ctrl  stl | rdy v  a      b      dst dwe ctrl
        tbl.push_back(mk(1, 1, 3, 16'd99, 1, 1, 2, 4, 1, 4'h5, 0,  0, 0, 16'd0,  16'd0,  0, 0, 4'h0)); // 0 reset
        tbl.push_back(mk(0, 0, 0, 16'd0,  1, 3, 0, 0, 0, 4'h2, 0,  1, 1, 16'd0,  16'd0,  0, 0, 4'h2)); // 1 r3 dropped
        tbl.push_back(mk(0, 1, 5, 16'd11, 1, 5, 0, 1, 0, 4'h3, 0,  1, 1, 16'd11, 16'd0,  1, 0, 4'h3)); // 2 bypass
        tbl.push_back(mk(0, 0, 0, 16'd0,  1, 5, 5, 7, 1, LOAD, 0,  1, 1, 16'd11, 16'd11, 7, 1, LOAD)); // 3 load r7
        tbl.push_back(mk(0, 0, 0, 16'd0,  1, 7, 0, 8, 1, 4'h1, 0,  0, 0, 16'd11, 16'd11, 7, 1, LOAD)); // 4 RAW
        tbl.push_back(mk(0, 0, 0, 16'd0,  1, 7, 0, 8, 1, 4'h1, 0,  0, 0, 16'd11, 16'd11, 7, 1, LOAD)); // 5 RAW
        tbl.push_back(mk(0, 1, 7, 16'd10, 1, 7, 0, 8, 1, 4'h1, 0,  1, 1, 16'd10, 16'd0,  8, 1, 4'h1)); // 6 release
        tbl.push_back(mk(0, 0, 0, 16'd0,  1, 5, 0, 9, 0, 4'h2, 1,  0, 1, 16'd10, 16'd0,  8, 1, 4'h1)); // 7 stall
        tbl.push_back(mk(0, 0, 0, 16'd0,  1, 5, 0, 9, 0, 4'h2, 1,  0, 1, 16'd10, 16'd0,  8, 1, 4'h1)); // 8 stall
        tbl.push_back(mk(0, 0, 0, 16'd0,  1, 5, 0, 9, 0, 4'h2, 1,  0, 1, 16'd10, 16'd0,  8, 1, 4'h1)); // 9 stall
        tbl.push_back(mk(0, 0, 0, 16'd0,  1, 5, 0, 9, 0, 4'h2, 0,  1, 1, 16'd11, 16'd0,  9, 0, 4'h2)); // 10 go
        tbl.push_back(mk(0, 0, 0, 16'd0,  1, 0, 0, 2, 1, 4'h4, 0,  1, 1, 16'd0,  16'd0,  2, 1, 4'h4)); // 11 dest r2
        tbl.push_back(mk(0, 0, 0, 16'd0,  1, 0, 0, 2, 1, 4'h6, 0,  0, 0, 16'd0,  16'd0,  2, 1, 4'h4)); // 12 WAW
        tbl.push_back(mk(0, 1, 2, 16'd7,  1, 0, 0, 2, 1, 4'h6, 0,  1, 1, 16'd0,  16'd0,  2, 1, 4'h6)); // 13 set wins
        tbl.push_back(mk(0, 0, 0, 16'd0,  1, 2, 0, 3, 0, 4'h8, 0,  0, 0, 16'd0,  16'd0,  2, 1, 4'h6)); // 14 r2 pend
        tbl.push_back(mk(0, 0, 0, 16'd0,  1, 0, 0, 0, 1, STORE,0,  1, 1, 16'd0,  16'd0,  0, 1, STORE));// 15 dest r0
        tbl.push_back(mk(0, 0, 0, 16'd0,  1, 0, 0, 0, 1, 4'h3, 0,  1, 1, 16'd0,  16'd0,  0, 1, 4'h3)); // 16 no stall
        tbl.push_back(mk(0, 1, 0, 16'd55, 1, 0, 0, 10,0, 4'h7, 0,  1, 1, 16'd0,  16'd0, 10, 0, 4'h7)); // 17 wb r0
        tbl.push_back(mk(0, 1, 2, 16'd8,  1, 2, 5, 0, 0, 4'h0, 0,  1, 1, 16'd8,  16'd11, 0, 0, 4'h0)); // 18 r2 wb
        tbl.push_back(mk(0, 0, 0, 16'd0,  1, 2, 3, 0, 0, 4'h9, 0,  1, 1, 16'd8,  16'd0,  0, 0, 4'h9)); // 19 regs
        tbl.push_back(mk(0, 0, 0, 16'd0,  0, 0, 0, 0, 0, 4'h0, 0,  0, 0, 16'd8,  16'd0,  0, 0, 4'h9)); // 20 idle

        @(posedge clk); #1;
        foreach (tbl[i]) begin
            drive(tbl[i]);
            #3;
            chk("ready_id", i, 32'(bus.ready_id), 32'(tbl[i].e_rdy));
            @(posedge clk); #1;
            chk_ex(i, tbl[i]);
        end

        // randomized run; narrow index range so hazards and bypasses collide often
        for (int c = 0; c < 600; c++) begin
            s       = tbl[0];
            s.rst   = (c == 0) || ($urandom_range(0, 99) == 0);
            s.wen   = ($urandom_range(0, 2) == 0);
            s.widx  = 5'($urandom_range(0, 7));
            s.wdata = 16'($urandom);
            s.vld   = ($urandom_range(0, 3) != 0);
            s.sa    = 5'($urandom_range(0, 7));
            s.sb    = 5'($urandom_range(0, 7));
            s.dst   = 5'($urandom_range(0, 7));
            s.dwe   = 1'($urandom_range(0, 1));
            s.ctrl  = 4'($urandom);
            s.stall = ($urandom_range(0, 3) == 0);
            drive(s);
            #3;
            chk("rnd_ready", 1000 + c, 32'(bus.ready_id), 32'(m_ready(s)));
            m_step(s);
            @(posedge clk); #1;
            s.e_v = m_v; s.e_a = m_a; s.e_b = m_b; s.e_dst = m_dst; s.e_dwe = m_dwe; s.e_ctrl = m_ctrl;
            chk_ex(1000 + c, s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
